// File: rtl/gshare_pattern_history_table.sv
// Gshare direction predictor: a table of saturating counters indexed by PC XOR GHR,
// with speculative history shift at fetch and commit-time training/repair.
module gshare_pattern_history_table #(
  parameter int ENTRY_WIDTH = 2,
  parameter int INDEX_WIDTH = 9,
  parameter int HIST_WIDTH  = 6,
  parameter int INIT_VALUE  = (1 << (ENTRY_WIDTH - 1)) - 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   ready,
  input  logic                   pred_valid,
  input  logic [INDEX_WIDTH-1:0] pred_pc_idx,
  output logic                   pred_taken,
  output logic [HIST_WIDTH-1:0]  pred_hist,
  input  logic                   upd_valid,
  input  logic [INDEX_WIDTH-1:0] upd_pc_idx,
  input  logic [HIST_WIDTH-1:0]  upd_hist,
  input  logic                   upd_taken,
  input  logic                   upd_mispredict,
  output logic [CNT_WIDTH-1:0]   mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] LAST_PTR = INDEX_WIDTH'(ENTRIES - 1);
  localparam logic [ENTRY_WIDTH-1:0] INIT_ENTRY = ENTRY_WIDTH'(INIT_VALUE);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [INDEX_WIDTH-1:0] r_ptr;
  logic [HIST_WIDTH-1:0]  r_ghr;
  logic [HIST_WIDTH-1:0]  w_ghr_nxt;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [ENTRY_WIDTH-1:0] r_table [ENTRIES];

  logic                   w_run;
  logic                   w_pred_fire;
  logic                   w_upd_fire;
  logic                   w_repair;
  logic [INDEX_WIDTH-1:0] w_pred_idx;
  logic [INDEX_WIDTH-1:0] w_upd_idx;
  logic [ENTRY_WIDTH-1:0] w_upd_entry;
  logic [ENTRY_WIDTH-1:0] w_upd_next;

  assign w_run       = (r_state == ST_RUN);
  assign w_pred_fire = w_run & pred_valid;
  assign w_upd_fire  = w_run & upd_valid;
  assign w_repair    = w_upd_fire & upd_mispredict;

  // History is zero-extended into the low index bits before hashing.
  assign w_pred_idx  = pred_pc_idx ^ INDEX_WIDTH'(r_ghr);
  assign w_upd_idx   = upd_pc_idx ^ INDEX_WIDTH'(upd_hist);

  assign pred_taken  = r_table[w_pred_idx][ENTRY_WIDTH-1];
  assign pred_hist   = r_ghr;
  assign ready       = w_run;
  assign mispredict_count = r_cnt;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal assigned in a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_ptr == LAST_PTR) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_ptr <= '0;
    else if (!w_run)     r_ptr <= r_ptr + 1'b1;
  end

  // Repair from commit overrides the speculative fetch-time shift.
  always_comb begin
    w_ghr_nxt = r_ghr;
    if (w_repair)         w_ghr_nxt = (upd_hist << 1) | HIST_WIDTH'(upd_taken);
    else if (w_pred_fire) w_ghr_nxt = (r_ghr << 1) | HIST_WIDTH'(pred_taken);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ghr <= '0;
    else        r_ghr <= w_ghr_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_cnt <= '0;
    else if (w_repair && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  end

  assign w_upd_entry = r_table[w_upd_idx];

  always_comb begin
    w_upd_next = w_upd_entry;
    if (upd_taken) begin
      if (!(&w_upd_entry)) w_upd_next = w_upd_entry + 1'b1;
    end else begin
      if (w_upd_entry != '0) w_upd_next = w_upd_entry - 1'b1;
    end
  end

  // NOTE: the counter array has no reset; the post-reset sweep initialises it, keeping it a plain RAM.
  always_ff @(posedge clk) begin
    if (!w_run)          r_table[r_ptr]     <= INIT_ENTRY;
    else if (w_upd_fire) r_table[w_upd_idx] <= w_upd_next;
  end

endmodule

// File: doc/gshare_pattern_history_table.md
# gshare_pattern_history_table

Parametrised gshare direction predictor for the fetch stage. It indexes a table of saturating counters with the fetch index XOR a speculative global history register (GHR). Commit-time outcomes train the counters and repair the GHR on a mispredict. After reset, a sweep state machine initialises every counter before any prediction is accepted.

## Interface
Parameters:
- ENTRY_WIDTH, 2, bits per saturating counter (legal range 1 to 4).
- INDEX_WIDTH, 9, table index width; the table holds 2^INDEX_WIDTH entries.
- HIST_WIDTH, 6, GHR length in bits; must be ≤ INDEX_WIDTH.
- INIT_VALUE, 2^(ENTRY_WIDTH-1)-1, counter value written by the init sweep (weakly not-taken).
- CNT_WIDTH, 16, width of the mispredict counter.

Ports (clock and reset first):
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ready  out  1  high once the init sweep completes.
- pred_valid  in  1  a fetched branch requests a prediction this cycle.
- pred_pc_idx  in  INDEX_WIDTH  PC-derived index.
- pred_taken  out  1  MSB of the selected counter (combinational).
- pred_hist  out  HIST_WIDTH  GHR value used for this prediction; travels down the pipe with the branch.
- upd_valid  in  1  a branch resolved at commit.
- upd_pc_idx  in  INDEX_WIDTH  PC index of the resolved branch.
- upd_hist  in  HIST_WIDTH  the pred_hist captured when the branch was predicted.
- upd_taken  in  1  actual outcome.
- upd_mispredict  in  1  prediction differed from outcome.
- mispredict_count  out  CNT_WIDTH  saturating count of accepted mispredicts.

## Operation
- Index: idx = pc_idx XOR {0, hist}. The history is zero-extended into the low bits. The same rule applies on the predict path (hist = GHR) and the update path (hist = upd_hist).
- FSM states:
  - INIT: ptr counts 0 .. 2^INDEX_WIDTH-1 and writes INIT_VALUE to entry ptr each cycle. ready=0. pred_valid and upd_valid are ignored: no GHR change, no counter change, no count change.
  - RUN: entered after ptr reaches the last entry. ready=1. Remains in RUN until rst_n asserts.
- Predict, in RUN with pred_valid=1:
  - pred_taken = counter[idx][ENTRY_WIDTH-1].
  - pred_hist = current GHR.
  - GHR <= {GHR[HIST_WIDTH-2:0], pred_taken} at the clock edge (speculative shift).
- pred_taken and pred_hist are driven every cycle from the current GHR and pred_pc_idx; they are meaningful only when ready=1.
- Update, in RUN with upd_valid=1:
  - upd_taken=1: the counter increments, saturating at 2^ENTRY_WIDTH-1.
  - upd_taken=0: the counter decrements, saturating at 0.
  - upd_mispredict=1: GHR <= {upd_hist[HIST_WIDTH-2:0], upd_taken}, and mispredict_count increments, saturating at all-ones.
- Simultaneous predict and update:
  - The predict read returns the pre-update counter value, even when both paths hit the same index (read-before-write).
  - If upd_mispredict=1, the repair value wins over the speculative shift.
  - If upd_mispredict=0, the speculative shift applies.
- One table write port: in RUN only the update path writes; in INIT only the sweep writes.

## Timing
- Reset values (asynchronous on rst_n low): FSM=INIT, ptr=0, GHR=0, mispredict_count=0, ready=0.
- Reset does not clear the table array; the sweep initialises it. Reset asserted mid-sweep or mid-RUN restarts the sweep from ptr=0 on the first edge after rst_n deasserts.
- The first rising edge after rst_n deasserts writes entry 0. ready rises on the edge that writes entry 2^INDEX_WIDTH-1, i.e. 2^INDEX_WIDTH cycles after deassertion.
- Prediction latency: zero cycles (combinational from pred_pc_idx and GHR). GHR and counter changes are visible the cycle after the edge.
- Update latency: a trained counter is visible to predictions from the next cycle onward.
- GHR wrap: the oldest bit is discarded on every shift. With HIST_WIDTH = INDEX_WIDTH, all index bits are hashed.

## Test plan
- Reset/init, with INDEX_WIDTH=4: deassert rst_n → ready=0 for exactly 16 cycles, then 1. Every index then predicts not-taken. mispredict_count=0 and GHR=0.
- Saturation, single idx, GHR held at 0 (no pred_valid): 3 upd_taken=1 updates from INIT_VALUE=1 saturate at 3, and a 4th update leaves it at 3. Then 4 upd_taken=0 updates end at 0, with pred_taken flipping to 0 after the 2nd.
- Speculative history: pred_valid for 3 cycles with the table trained so the predictions are 1,0,1 → GHR=…101. pred_hist for each request equals the GHR before that shift.
- Mispredict repair in the same cycle as a pred_valid, with upd_hist=6'b010011 and upd_taken=0 → next GHR=6'b100110, not the shifted value. mispredict_count increments by 1.
- Same-index collision: entry=1. Apply predict and update(taken) to the same idx in the same cycle → pred_taken=0 that cycle, and a prediction of that idx the next cycle returns 1.
- rst_n pulsed low mid-RUN after training → ready drops asynchronously, a full 2^INDEX_WIDTH-cycle sweep reruns, and all entries return to INIT_VALUE.
